// File: rtl/vga_frame_reader.sv
// vga_frame_reader: VGA timing generator that shows a centred greyscale framebuffer window inside a constant border.
// Latency: 2 cycles from the counters to HS/VS/BLANK_N/RGB/frame_start; FB_ADDR leads its pixel by 1 cycle.
// Backpressure: none; the pixel stream free-runs and the framebuffer is read on every in-window cycle.
module vga_frame_reader #(
  parameter int         H_VISIBLE = 640,
  parameter int         H_FP      = 16,
  parameter int         H_SYNC    = 96,
  parameter int         H_BP      = 48,
  parameter int         V_VISIBLE = 480,
  parameter int         V_FP      = 10,
  parameter int         V_SYNC    = 2,
  parameter int         V_BP      = 33,
  parameter int         FB_DEPTH  = 76800,
  parameter logic [7:0] BORDER    = 8'h00
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [9:0]  IMG_WIDTH_OUT,
  input  logic [8:0]  IMG_HEIGHT_OUT,
  input  logic        fb_valid,
  input  logic        display_enable,
  input  logic [7:0]  FB_DATA,
  output logic [16:0] FB_ADDR,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Counters are 11 bits wide, which covers every standard mode up to 2047 clocks per line.
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [19:0] DEPTH  = 20'(FB_DEPTH);

  // Stage 0: raster position
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        frame_latch;

  // Per-frame window geometry, frozen between latches
  logic [10:0] w_ext, ht_ext;
  logic [19:0] area;
  logic [10:0] x_off_c, y_off_c;
  logic [10:0] x_off_q, x_off_d, x_end_q, x_end_d;
  logic [10:0] y_off_q, y_off_d, y_end_q, y_end_d;
  logic        win_en_q, win_en_d;

  // Stage 0 decoded flags
  logic vis_s0, hs_s0, vs_s0, win_s0, fs_s0;

  // Stage 1: read address and delayed flags
  logic [16:0] addr_cnt_q, addr_cnt_d;
  logic [16:0] fb_addr_q, fb_addr_d;
  logic        vis_s1_q, hs_s1_q, vs_s1_q, win_s1_q, fs_s1_q;

  // Stage 2: output registers (read data arrives alongside them)
  logic        vis_s2_q, hs_s2_q, vs_s2_q, win_s2_q, fs_s2_q, en_s2_q;
  logic [7:0]  pix;

  // Next raster position: the line counter only moves when the pixel counter wraps.
  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
    end
  end

  // Raster counter registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // The last clock of the frame is the only point where geometry may change, so a frame never tears.
  assign frame_latch = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

  assign w_ext   = {1'b0, IMG_WIDTH_OUT};
  assign ht_ext  = {2'b00, IMG_HEIGHT_OUT};
  // Evaluated once per frame only; the per-pixel path uses plain compares and an incrementing address.
  assign area    = 20'(IMG_WIDTH_OUT) * 20'(IMG_HEIGHT_OUT);
  // Flooring the half-margin leaves any odd column/line on the right/bottom border.
  assign x_off_c = (H_VIS - w_ext) >> 1;
  assign y_off_c = (V_VIS - ht_ext) >> 1;

  // Capture window geometry and validity at the frame latch; hold it otherwise.
  always_comb begin
    x_off_d  = x_off_q;
    x_end_d  = x_end_q;
    y_off_d  = y_off_q;
    y_end_d  = y_end_q;
    win_en_d = win_en_q;
    if (frame_latch) begin
      x_off_d  = x_off_c;
      x_end_d  = x_off_c + w_ext;
      y_off_d  = y_off_c;
      y_end_d  = y_off_c + ht_ext;
      // Offsets may be garbage for oversize images, but the window is then disabled anyway.
      win_en_d = fb_valid && (w_ext != '0) && (ht_ext != '0) &&
                 (w_ext <= H_VIS) && (ht_ext <= V_VIS) && (area <= DEPTH);
    end
  end

  // Geometry registers; the first frame after reset is border only.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      x_off_q  <= '0;
      x_end_q  <= '0;
      y_off_q  <= '0;
      y_end_q  <= '0;
      win_en_q <= 1'b0;
    end else begin
      x_off_q  <= x_off_d;
      x_end_q  <= x_end_d;
      y_off_q  <= y_off_d;
      y_end_q  <= y_end_d;
      win_en_q <= win_en_d;
    end
  end

  assign vis_s0 = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign hs_s0  = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
  assign vs_s0  = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
  assign fs_s0  = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign win_s0 = win_en_q &&
                  (h_cnt_q >= x_off_q) && (h_cnt_q < x_end_q) &&
                  (v_cnt_q >= y_off_q) && (v_cnt_q < y_end_q);

  // Raster-order address: restart at the latch, issue and advance only inside the window.
  always_comb begin
    addr_cnt_d = addr_cnt_q;
    fb_addr_d  = fb_addr_q;
    if (frame_latch) begin
      addr_cnt_d = '0;
    end else if (win_s0) begin
      fb_addr_d  = addr_cnt_q;
      addr_cnt_d = addr_cnt_q + 17'd1;
    end
  end

  // Stage 1 registers: read address plus flags delayed to match it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      addr_cnt_q <= '0;
      fb_addr_q  <= '0;
      vis_s1_q   <= 1'b0;
      hs_s1_q    <= 1'b0;
      vs_s1_q    <= 1'b0;
      win_s1_q   <= 1'b0;
      fs_s1_q    <= 1'b0;
    end else begin
      addr_cnt_q <= addr_cnt_d;
      fb_addr_q  <= fb_addr_d;
      vis_s1_q   <= vis_s0;
      hs_s1_q    <= hs_s0;
      vs_s1_q    <= vs_s0;
      win_s1_q   <= win_s0;
      fs_s1_q    <= fs_s0;
    end
  end

  // Stage 2 registers: flags line up with the RAM data returned for the stage-1 address.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vis_s2_q <= 1'b0;
      hs_s2_q  <= 1'b0;
      vs_s2_q  <= 1'b0;
      win_s2_q <= 1'b0;
      fs_s2_q  <= 1'b0;
      en_s2_q  <= 1'b0;
    end else begin
      vis_s2_q <= vis_s1_q;
      hs_s2_q  <= hs_s1_q;
      vs_s2_q  <= vs_s1_q;
      win_s2_q <= win_s1_q;
      fs_s2_q  <= fs_s1_q;
      en_s2_q  <= display_enable;
    end
  end

  // Pixel select: image in the window, border elsewhere in the visible area, black in blanking or when disabled.
  always_comb begin
    pix = 8'h00;
    if (en_s2_q && vis_s2_q) begin
      pix = win_s2_q ? FB_DATA : BORDER;
    end
  end

  assign FB_ADDR     = fb_addr_q;
  assign VGA_HS      = ~hs_s2_q;
  assign VGA_VS      = ~vs_s2_q;
  assign VGA_BLANK_N = vis_s2_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = pix;
  assign VGA_G       = pix;
  assign VGA_B       = pix;
  assign frame_start = fs_s2_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader: directed checks of vga_frame_reader on a scaled-down 64x48 raster (80x55 total).
// Latency: outputs sampled on the falling edge, two cycles behind the raster counters.
// Backpressure: none; a one-cycle-latency RAM model returns FB_ADDR[7:0].
module tb_vga_frame_reader;

  localparam int HT = 80;
  localparam int VT = 55;
  localparam int FRAME = HT * VT;
  localparam logic [7:0] BRD = 8'h5A;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [9:0]  IMG_WIDTH_OUT = 10'd0;
  logic [8:0]  IMG_HEIGHT_OUT = 9'd0;
  logic        fb_valid = 1'b0;
  logic        display_enable = 1'b0;
  logic [7:0]  FB_DATA = 8'h00;
  logic [16:0] FB_ADDR;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  int vectors = 0;
  int miscompares = 0;
  int tcnt = 0;

  int sc_rgb, sc_blank, sc_hs, sc_vs, sc_fs, sc_addr;
  int sc_hs_first, sc_hs_low0, sc_vs_first, sc_vs_low, sc_fs_cnt;

  vga_frame_reader #(
    .H_VISIBLE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VISIBLE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .FB_DEPTH(768), .BORDER(BRD)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .IMG_WIDTH_OUT(IMG_WIDTH_OUT), .IMG_HEIGHT_OUT(IMG_HEIGHT_OUT),
    .fb_valid(fb_valid), .display_enable(display_enable),
    .FB_DATA(FB_DATA), .FB_ADDR(FB_ADDR),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .frame_start(frame_start)
  );

  always #20 CLK = ~CLK;

  // Synchronous-read framebuffer model
  always @(posedge CLK) FB_DATA <= FB_ADDR[7:0];

  // Clocks since reset release = linear raster position of the DUT counters
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) tcnt <= 0;
    else          tcnt <= tcnt + 1;
  end

  function automatic int pos(input int f, input int h, input int v);
    return f * FRAME + v * HT + h;
  endfunction

  task automatic wait_tc(input int target, input string name);
    int guard;
    guard = 0;
    while (tcnt < target && guard < 20000) begin
      @(negedge CLK);
      guard++;
    end
    if (tcnt != target) begin
      vectors++; miscompares++;
      $display("FAIL %s: reached position %0d, required %0d", name, tcnt, target);
    end
  endtask

  // Observe one frame's output lines against the border-only picture, tallying disagreements.
  task automatic scan_frame(input int f, input int lines, input logic [16:0] addr_exp);
    sc_rgb = 0; sc_blank = 0; sc_hs = 0; sc_vs = 0; sc_fs = 0; sc_addr = 0;
    sc_hs_first = -1; sc_hs_low0 = 0; sc_vs_first = -1; sc_vs_low = 0; sc_fs_cnt = 0;
    wait_tc(pos(f, 0, 0) + 2, "scan_start");
    for (int p = 0; p < lines * HT; p++) begin
      int h, v;
      logic vis;
      h = p % HT;
      v = p / HT;
      vis = (h < 64) && (v < 48);
      if (VGA_BLANK_N !== vis) sc_blank++;
      if ({VGA_R, VGA_G, VGA_B} !== (vis ? {3{BRD}} : 24'h0)) sc_rgb++;
      if (VGA_HS !== !((h >= 68) && (h < 76))) sc_hs++;
      if (VGA_VS !== !((v >= 50) && (v < 52))) sc_vs++;
      if (frame_start !== (p == 0)) sc_fs++;
      if (FB_ADDR !== addr_exp) sc_addr++;
      if (VGA_HS === 1'b0) begin
        if (sc_hs_first < 0) sc_hs_first = p;
        if (v == 0) sc_hs_low0++;
      end
      if (VGA_VS === 1'b0) begin
        if (sc_vs_first < 0) sc_vs_first = p;
        sc_vs_low++;
      end
      if (frame_start === 1'b1) sc_fs_cnt++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    IMG_WIDTH_OUT = 10'd40; IMG_HEIGHT_OUT = 9'd24; fb_valid = 1'b1; display_enable = 1'b1;
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    vectors++; if (VGA_HS !== 1'b1) begin miscompares++; $display("FAIL reset_hs: got %b, required 1", VGA_HS); end
    vectors++; if (VGA_VS !== 1'b1) begin miscompares++; $display("FAIL reset_vs: got %b, required 1", VGA_VS); end
    vectors++; if (VGA_BLANK_N !== 1'b0) begin miscompares++; $display("FAIL reset_blank_n: got %b, required 0", VGA_BLANK_N); end
    vectors++; if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin miscompares++; $display("FAIL reset_rgb: got %h, required 000000", {VGA_R, VGA_G, VGA_B}); end
    vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL reset_frame_start: got %b, required 0", frame_start); end
    vectors++; if (FB_ADDR !== 17'd0) begin miscompares++; $display("FAIL reset_fb_addr: got %0d, required 0", FB_ADDR); end
    vectors++; if (VGA_SYNC_N !== 1'b0) begin miscompares++; $display("FAIL sync_n: got %b, required 0", VGA_SYNC_N); end
    RESET_N = 1'b1;
  endtask

  // Frame 0: the latched geometry is 40x24 (960 > 768), and the first frame is border only anyway.
  task automatic test_sync_timing;
    scan_frame(0, VT, 17'd0);
    vectors++; if (sc_blank !== 0) begin miscompares++; $display("FAIL f0_blank_n: %0d bad cycles, required 0", sc_blank); end
    vectors++; if (sc_rgb !== 0) begin miscompares++; $display("FAIL f0_border_rgb: %0d bad cycles, required 0", sc_rgb); end
    vectors++; if (sc_hs !== 0) begin miscompares++; $display("FAIL f0_hs: %0d bad cycles, required 0", sc_hs); end
    vectors++; if (sc_vs !== 0) begin miscompares++; $display("FAIL f0_vs: %0d bad cycles, required 0", sc_vs); end
    vectors++; if (sc_fs !== 0) begin miscompares++; $display("FAIL f0_frame_start: %0d bad cycles, required 0", sc_fs); end
    vectors++; if (sc_addr !== 0) begin miscompares++; $display("FAIL f0_fb_addr: %0d bad cycles, required 0", sc_addr); end
    vectors++; if (sc_hs_first !== 68) begin miscompares++; $display("FAIL hs_offset: HS fell %0d after BLANK_N rose, required 68", sc_hs_first); end
    vectors++; if (sc_hs_low0 !== 8) begin miscompares++; $display("FAIL hs_width: %0d low cycles, required 8", sc_hs_low0); end
    vectors++; if (sc_vs_first !== 4000) begin miscompares++; $display("FAIL vs_offset: VS fell at %0d, required 4000", sc_vs_first); end
    vectors++; if (sc_vs_low !== 160) begin miscompares++; $display("FAIL vs_width: %0d low cycles, required 160", sc_vs_low); end
    vectors++; if (sc_fs_cnt !== 1) begin miscompares++; $display("FAIL frame_start_count: %0d pulses, required 1", sc_fs_cnt); end
  endtask

  task automatic test_invalid_area;
    scan_frame(1, 48, 17'd0);
    vectors++; if (sc_rgb !== 0) begin miscompares++; $display("FAIL area_border_rgb: %0d bad cycles, required 0", sc_rgb); end
    vectors++; if (sc_addr !== 0) begin miscompares++; $display("FAIL area_fb_addr: %0d bad cycles, required 0", sc_addr); end
    vectors++; if (sc_fs !== 0) begin miscompares++; $display("FAIL f1_frame_start: %0d bad cycles, required 0", sc_fs); end
    IMG_WIDTH_OUT = 10'd32; fb_valid = 1'b0;
  endtask

  task automatic test_fb_invalid;
    scan_frame(2, 48, 17'd0);
    vectors++; if (sc_rgb !== 0) begin miscompares++; $display("FAIL nofb_border_rgb: %0d bad cycles, required 0", sc_rgb); end
    vectors++; if (sc_addr !== 0) begin miscompares++; $display("FAIL nofb_fb_addr: %0d bad cycles, required 0", sc_addr); end
    vectors++; if (sc_blank !== 0) begin miscompares++; $display("FAIL nofb_blank_n: %0d bad cycles, required 0", sc_blank); end
    fb_valid = 1'b1;
  endtask

  // Frame 3: 32x24 window at X_OFF=16, Y_OFF=12
  task automatic test_image;
    int bad;
    wait_tc(pos(3, 16, 11) + 2, "img_wait0");
    vectors++; if (VGA_R !== BRD) begin miscompares++; $display("FAIL img_above: got %h, required %h", VGA_R, BRD); end
    wait_tc(pos(3, 16, 12) + 1, "img_wait1");
    vectors++; if (VGA_G !== BRD) begin miscompares++; $display("FAIL img_left: got %h, required %h", VGA_G, BRD); end
    vectors++; if (FB_ADDR !== 17'd0) begin miscompares++; $display("FAIL addr_first: got %0d, required 0", FB_ADDR); end
    @(negedge CLK);
    vectors++; if ({VGA_R, VGA_G, VGA_B} !== 24'h000000) begin miscompares++; $display("FAIL img_first: got %h, required 000000", {VGA_R, VGA_G, VGA_B}); end
    vectors++; if (FB_ADDR !== 17'd1) begin miscompares++; $display("FAIL addr_second: got %0d, required 1", FB_ADDR); end
    @(negedge CLK);
    vectors++; if ({VGA_R, VGA_G, VGA_B} !== 24'h010101) begin miscompares++; $display("FAIL img_second: got %h, required 010101", {VGA_R, VGA_G, VGA_B}); end
    wait_tc(pos(3, 47, 12) + 1, "img_wait2");
    vectors++; if (FB_ADDR !== 17'd31) begin miscompares++; $display("FAIL addr_line_end: got %0d, required 31", FB_ADDR); end
    bad = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge CLK);
      if (FB_ADDR !== 17'd31) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL addr_hold: %0d changed cycles, required 0", bad); end
    @(negedge CLK);
    vectors++; if (FB_ADDR !== 17'd32) begin miscompares++; $display("FAIL addr_next_line: got %0d, required 32", FB_ADDR); end
    @(negedge CLK);
    vectors++; if (VGA_B !== 8'h20) begin miscompares++; $display("FAIL img_next_line: got %h, required 20", VGA_B); end
    wait_tc(pos(3, 47, 35) + 2, "img_wait3");
    vectors++; if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF) begin miscompares++; $display("FAIL img_last: got %h, required ffffff", {VGA_R, VGA_G, VGA_B}); end
    vectors++; if (FB_ADDR !== 17'd767) begin miscompares++; $display("FAIL addr_last: got %0d, required 767", FB_ADDR); end
    @(negedge CLK);
    vectors++; if (VGA_R !== BRD) begin miscompares++; $display("FAIL img_right: got %h, required %h", VGA_R, BRD); end
  endtask

  // Width 32 -> 16 at line 20 of frame 4; frame 5 then uses X_OFF=24, window h in [24,40)
  task automatic test_mid_frame_change;
    wait_tc(pos(4, 16, 12) + 2, "mid_wait0");
    vectors++; if (VGA_R !== 8'h00) begin miscompares++; $display("FAIL mid_first: got %h, required 00", VGA_R); end
    wait_tc(pos(4, 0, 20), "mid_wait1");
    IMG_WIDTH_OUT = 10'd16;
    wait_tc(pos(4, 15, 30) + 2, "mid_wait2");
    vectors++; if (VGA_R !== BRD) begin miscompares++; $display("FAIL mid_left: got %h, required %h", VGA_R, BRD); end
    @(negedge CLK);
    vectors++; if (VGA_R !== 8'h40) begin miscompares++; $display("FAIL mid_row30: got %h, required 40", VGA_R); end
    wait_tc(pos(4, 47, 30) + 2, "mid_wait3");
    vectors++; if (VGA_R !== 8'h5F) begin miscompares++; $display("FAIL mid_row30_end: got %h, required 5f", VGA_R); end
    wait_tc(pos(5, 23, 12) + 2, "mid_wait4");
    vectors++; if (VGA_R !== BRD) begin miscompares++; $display("FAIL new_left: got %h, required %h", VGA_R, BRD); end
    @(negedge CLK);
    vectors++; if (VGA_R !== 8'h00) begin miscompares++; $display("FAIL new_first: got %h, required 00", VGA_R); end
    wait_tc(pos(5, 39, 12) + 2, "mid_wait5");
    vectors++; if (VGA_R !== 8'h0F) begin miscompares++; $display("FAIL new_line_end: got %h, required 0f", VGA_R); end
    @(negedge CLK);
    vectors++; if (VGA_R !== BRD) begin miscompares++; $display("FAIL new_right: got %h, required %h", VGA_R, BRD); end
    wait_tc(pos(5, 24, 13) + 2, "mid_wait6");
    vectors++; if (VGA_R !== 8'h10) begin miscompares++; $display("FAIL new_second_line: got %h, required 10", VGA_R); end
  endtask

  task automatic test_fb_valid_drop;
    wait_tc(pos(5, 0, 20), "drop_wait0");
    fb_valid = 1'b0;
    wait_tc(pos(5, 24, 30) + 2, "drop_wait1");
    vectors++; if (VGA_R !== 8'h20) begin miscompares++; $display("FAIL drop_same_frame: got %h, required 20", VGA_R); end
    wait_tc(pos(5, 39, 35) + 2, "drop_wait2");
    vectors++; if (VGA_R !== 8'h7F) begin miscompares++; $display("FAIL drop_last: got %h, required 7f", VGA_R); end
    wait_tc(pos(6, 24, 12) + 2, "drop_wait3");
    vectors++; if (VGA_R !== BRD) begin miscompares++; $display("FAIL drop_next_border: got %h, required %h", VGA_R, BRD); end
    vectors++; if (FB_ADDR !== 17'd383) begin miscompares++; $display("FAIL drop_addr_hold: got %0d, required 383", FB_ADDR); end
  endtask

  task automatic test_reset_mid_frame;
    wait_tc(pos(6, 50, 30), "rst_wait0");
    RESET_N = 1'b0;
    #1;
    vectors++; if ({VGA_HS, VGA_VS, VGA_BLANK_N, frame_start} !== 4'b1100) begin miscompares++; $display("FAIL midrst_ctrl: got %b, required 1100", {VGA_HS, VGA_VS, VGA_BLANK_N, frame_start}); end
    vectors++; if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin miscompares++; $display("FAIL midrst_rgb: got %h, required 000000", {VGA_R, VGA_G, VGA_B}); end
    vectors++; if (FB_ADDR !== 17'd0) begin miscompares++; $display("FAIL midrst_addr: got %0d, required 0", FB_ADDR); end
    IMG_WIDTH_OUT = 10'd32; fb_valid = 1'b1;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    scan_frame(0, 48, 17'd0);
    vectors++; if (sc_fs !== 0) begin miscompares++; $display("FAIL post_rst_restart: %0d bad frame_start cycles, required 0", sc_fs); end
    vectors++; if (sc_rgb !== 0) begin miscompares++; $display("FAIL post_rst_border: %0d bad cycles, required 0", sc_rgb); end
    vectors++; if (sc_hs !== 0) begin miscompares++; $display("FAIL post_rst_hs: %0d bad cycles, required 0", sc_hs); end
    wait_tc(pos(1, 16, 12) + 2, "rst_wait1");
    vectors++; if (VGA_R !== 8'h00) begin miscompares++; $display("FAIL post_rst_img0: got %h, required 00", VGA_R); end
    @(negedge CLK);
    vectors++; if (VGA_R !== 8'h01) begin miscompares++; $display("FAIL post_rst_img1: got %h, required 01", VGA_R); end
  endtask

  task automatic test_display_enable;
    wait_tc(pos(1, 0, 20), "den_wait0");
    display_enable = 1'b0;
    wait_tc(pos(1, 16, 30) + 2, "den_wait1");
    vectors++; if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin miscompares++; $display("FAIL den_rgb: got %h, required 000000", {VGA_R, VGA_G, VGA_B}); end
    vectors++; if (VGA_BLANK_N !== 1'b1) begin miscompares++; $display("FAIL den_blank_n: got %b, required 1", VGA_BLANK_N); end
    wait_tc(pos(1, 0, 33), "den_wait2");
    display_enable = 1'b1;
    wait_tc(pos(1, 47, 35) + 2, "den_wait3");
    vectors++; if (VGA_R !== 8'hFF) begin miscompares++; $display("FAIL den_restore: got %h, required ff", VGA_R); end
  endtask

  initial begin
    test_reset();
    test_sync_timing();
    test_invalid_area();
    test_fb_invalid();
    test_image();
    test_mid_frame_change();
    test_fb_valid_drop();
    test_reset_mid_frame();
    test_display_enable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Display-side consumer of the output framebuffer written by the zoom data-management stage. Generates 640x480@60 VGA timing from a 25 MHz pixel clock, reads the 8-bit greyscale framebuffer through its second (read) port, and shows the zoomed image centred on screen with a constant border colour around it. Window geometry and image validity are sampled once per frame, so the displayed frame never tears while the zoom stage rewrites the buffer.

## Interface
Parameters:
- H_VISIBLE, 640, active pixels per line; H_FP 16, H_SYNC 96, H_BP 48 (H_TOTAL = 800)
- V_VISIBLE, 480, active lines; V_FP 10, V_SYNC 2, V_BP 33 (V_TOTAL = 525)
- FB_DEPTH, 76800, framebuffer capacity in pixels
- BORDER, 8'h00, grey level outside the image window

Ports:
- CLK  in  1  25 MHz pixel clock; single clock domain
- RESET_N  in  1  asynchronous, active-low reset
- IMG_WIDTH_OUT  in  10  zoomed image width in pixels
- IMG_HEIGHT_OUT  in  9  zoomed image height in lines
- fb_valid  in  1  high when the framebuffer holds a complete image (zoom stage done)
- display_enable  in  1  low forces RGB to 0; syncs keep running
- FB_DATA  in  8  framebuffer read data; 1-cycle synchronous read latency
- FB_ADDR  out  17  framebuffer read address (registered)
- VGA_HS, VGA_VS  out  1  sync pulses, active-low
- VGA_BLANK_N  out  1  high during the visible area
- VGA_SYNC_N  out  1  tied 0
- VGA_R, VGA_G, VGA_B  out  8  grey level, all three equal
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

## Operation
- Counters: h_cnt 0..H_TOTAL-1; at wrap, v_cnt increments, 0..V_TOTAL-1.
- Visible area: h_cnt < 640 and v_cnt < 480. HS is low for h_cnt in [656,752). VS is low for v_cnt in [490,492).
- Frame latch occurs when (h_cnt, v_cnt) = (799, 524):
  - latch W = IMG_WIDTH_OUT and H = IMG_HEIGHT_OUT;
  - latch X_OFF = (640-W)>>1 and Y_OFF = (480-H)>>1;
  - win_en = fb_valid and W≠0 and H≠0 and W≤640 and H≤480 and W*H≤FB_DEPTH.
- Input changes between latches have no effect.
- In-window: win_en and h_cnt in [X_OFF, X_OFF+W) and v_cnt in [Y_OFF, Y_OFF+H).
- Address counter:
  - cleared to 0 at the frame latch;
  - FB_ADDR <= addr_cnt on each in-window cycle, then addr_cnt increments;
  - FB_ADDR holds its value outside the window.
  - The resulting address is (v-Y_OFF)*W + (h-X_OFF), with no multiplier in the per-pixel path.
- Pixel select:
  - in-window: FB_DATA;
  - visible but outside the window: BORDER;
  - blanking: 0;
  - display_enable low (sampled in the output stage): 0.
- States:
  - RUN is the only steady state.
  - After reset, win_en = 0, so the first frame shows border only. The image appears from the second frame on.

## Timing
- Pipeline:
  - stage 0: counters;
  - stage 1: FB_ADDR and delayed flags;
  - RAM returns FB_DATA in stage 2;
  - stage 2: output registers.
- Counter-to-output latency is 2 cycles for HS, VS, BLANK_N, RGB and frame_start. All outputs are delayed equally, so relative sync timing is exact.
- FB_ADDR leads its RGB output by exactly 1 cycle.
- Reset values (asynchronous, RESET_N low):
  - h_cnt, v_cnt, addr_cnt, FB_ADDR = 0;
  - VGA_HS = VGA_VS = 1;
  - VGA_BLANK_N = 0, RGB = 0, frame_start = 0;
  - win_en = 0; delay pipeline cleared to blank/no-sync.
- Reset mid-frame: outputs return to reset values immediately. After release, counting restarts at (0,0) and the first frame is border only.
- W = 640 and H = 480 with FB_DEPTH ≥ 307200: X_OFF = Y_OFF = 0 and there is no border.
- Odd margins: the extra column or line goes to the right or bottom border.
- fb_valid dropping mid-frame: the current frame still shows the image. Border-only display starts from the next latch.
- frame_start: high for exactly 1 cycle per 420000 cycles.

## Test plan
- Reset, then run 2 frames. Required:
  - HS period 800 cycles, HS low for 96 cycles starting 656 cycles after BLANK_N rises;
  - VS low for 2 lines (1600 cycles);
  - frame_start every 420000 cycles;
  - first frame RGB = BORDER throughout the visible area.
- W=320, H=240, fb_valid=1, RAM model returns addr[7:0]. Required in the second frame:
  - output (160,120) = 0x00 and (161,120) = 0x01;
  - (479,359) = (76799 mod 256) = 0xFF;
  - (159,120) = BORDER, and (160,119) = BORDER.
- FB_ADDR sequence in the second frame with W=320, H=240:
  - 0 at h=160, v=120; 319 at h=479, v=120; 320 at h=160, v=121;
  - no change outside the window;
  - FB_ADDR precedes the matching RGB by 1 cycle.
- Change IMG_WIDTH_OUT 320->160 at mid-frame (v=200). Required:
  - the current frame is unchanged;
  - the next frame has X_OFF = 240 and the window spans h in [240,400).
- W=400, H=300 (120000 > FB_DEPTH); separately, fb_valid=0 with W=320, H=240. Each case is latched for a full frame. Required: the entire visible area is BORDER and FB_ADDR stays at 0.
- RESET_N pulsed low at v=300, h=500. Required:
  - all outputs take their reset values in the same cycle;
  - after release, the counters restart at 0;
  - the following frame is border only;
  - the image returns the frame after that.
